// File: rtl/jt12_ch_acc.sv
// jt12_ch_acc: per-channel operator accumulator for a 6-channel FM voice engine.
//
// The operator pipeline delivers one operator output per slot. The slot order is
// S1 ch0..5, S3 ch0..5, S2 ch0..5, S4 ch0..5, which gives a 24-slot frame. The
// carrier outputs of each channel are summed in a circulating buffer. After the
// S4 slot of a channel, the saturated sum is presented with a one-slot strobe.
//
// Ports
//   clk, rst             system clock, asynchronous active-high reset
//   clk_en               slot advance; state moves only on enabled edges
//   zero                 marks the S1/ch0 slot, the start of a frame
//   s1..s4_enters        one-hot operator group of op_result
//   alg                  algorithm of the channel in the current slot
//   op_result            signed 14-bit operator output for the current slot
//   en_dac, dac_val      DAC sample replaces channel 5's sum when enabled
//   snd, snd_ch          saturated channel sum and its channel index
//   snd_valid            snd/snd_ch were updated on the last enabled edge
module jt12_ch_acc #(
    parameter int unsigned num_ch = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               zero,
    input  logic               s1_enters,
    input  logic               s2_enters,
    input  logic               s3_enters,
    input  logic               s4_enters,
    input  logic [2:0]         alg,
    input  logic signed [13:0] op_result,
    input  logic               en_dac,
    input  logic signed [8:0]  dac_val,
    output logic signed [13:0] snd,
    output logic [2:0]         snd_ch,
    output logic               snd_valid
);

    localparam logic [2:0] LastCh = 3'(num_ch - 1);

    // r_buf[0] always belongs to the channel of the current slot
    logic signed [15:0] r_buf [num_ch];
    logic [2:0]         r_ch;
    logic               r_sync;

    logic [2:0]         w_ch;
    logic [2:0]         w_ch_nxt;
    logic [2:0]         w_nflags;
    logic               w_one_hot;
    logic               w_carrier;
    logic signed [15:0] w_op_ext;
    logic signed [15:0] w_add;
    logic signed [15:0] w_head;
    logic signed [15:0] w_entry_nxt;
    logic signed [16:0] w_total;
    logic signed [13:0] w_sat;
    logic signed [13:0] w_snd_nxt;
    logic               w_s4_slot;
    logic               w_strobe;

    // zero overrides the counter; a misaligned counter simply snaps back to 0
    assign w_ch     = zero ? 3'd0 : r_ch;
    assign w_ch_nxt = (w_ch == LastCh) ? 3'd0 : w_ch + 3'd1;

    assign w_nflags  = {2'b00, s1_enters} + {2'b00, s2_enters}
                     + {2'b00, s3_enters} + {2'b00, s4_enters};
    assign w_one_hot = (w_nflags == 3'd1);

    assign w_carrier = s4_enters
                     | (s2_enters & (alg >= 3'd4))
                     | (s3_enters & (alg >= 3'd5))
                     | (s1_enters & (alg == 3'd7));

    assign w_op_ext = {{2{op_result[13]}}, op_result};
    assign w_add    = w_carrier ? w_op_ext : 16'sd0;
    assign w_head   = r_buf[0];

    // The S4 sum is one bit wider so that it cannot wrap before saturation
    assign w_total = {w_head[15], w_head} + {{3{op_result[13]}}, op_result};

    always_comb begin
        w_sat = w_total[13:0];
        if (w_total > 17'sd8191) begin
            w_sat = 14'sd8191;
        end else if (w_total < -17'sd8192) begin
            w_sat = -14'sd8192;
        end
    end

    assign w_snd_nxt = (en_dac && (w_ch == LastCh)) ? {dac_val, 5'b0_0000} : w_sat;

    always_comb begin
        w_entry_nxt = w_head;
        if (w_one_hot) begin
            if (s1_enters) begin
                w_entry_nxt = w_add;
            end else if (s4_enters) begin
                w_entry_nxt = 16'sd0;
            end else begin
                w_entry_nxt = w_head + w_add;
            end
        end
    end

    assign w_s4_slot = w_one_hot & s4_enters;
    // zero is included so that a frame starting right at sync is not lost
    assign w_strobe  = w_s4_slot & (r_sync | zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(num_ch); i++) begin
                r_buf[i] <= '0;
            end
            r_ch      <= '0;
            r_sync    <= 1'b0;
            snd       <= '0;
            snd_ch    <= '0;
            snd_valid <= 1'b0;
        end else if (clk_en) begin
            for (int i = 0; i < int'(num_ch) - 1; i++) begin
                r_buf[i] <= r_buf[i+1];
            end
            r_buf[num_ch-1] <= w_entry_nxt;
            r_ch      <= w_ch_nxt;
            r_sync    <= r_sync | zero;
            snd_valid <= w_strobe;
            if (w_s4_slot) begin
                snd    <= w_snd_nxt;
                snd_ch <= w_ch;
            end
        end
    end

endmodule

// File: tb/tb_jt12_ch_acc.sv
// Scoreboard bench for jt12_ch_acc. Each S4 slot driven pushes the expected
// channel sum from a per-channel reference model. Strobes seen after enabled
// edges pop the queue and are compared against it.
module tb_jt12_ch_acc;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_en;
    logic               zero;
    logic               s1_enters, s2_enters, s3_enters, s4_enters;
    logic [2:0]         alg;
    logic signed [13:0] op_result;
    logic               en_dac;
    logic signed [8:0]  dac_val;
    logic signed [13:0] snd;
    logic [2:0]         snd_ch;
    logic               snd_valid;

    typedef struct {
        int snd;
        int ch;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_strobe;
    int   m_acc[6];
    bit   m_sync;
    int   ops[4];
    int   cur_alg;
    int   cur_gap;
    int   dac_i;

    always #5 clk = ~clk;

    jt12_ch_acc #(.num_ch(6)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .zero      (zero),
        .s1_enters (s1_enters),
        .s2_enters (s2_enters),
        .s3_enters (s3_enters),
        .s4_enters (s4_enters),
        .alg       (alg),
        .op_result (op_result),
        .en_dac    (en_dac),
        .dac_val   (dac_val),
        .snd       (snd),
        .snd_ch    (snd_ch),
        .snd_valid (snd_valid)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat14(input int t);
        if (t > 8191) return 8191;
        if (t < -8192) return -8192;
        return t;
    endfunction

    task automatic sample_outputs();
        exp_t e;
        if (snd_valid) begin
            n_strobe++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("snd", int'(snd), e.snd);
                check("snd_ch", int'(snd_ch), e.ch);
            end
        end
    endtask

    // Slot index s: group g = s/6 (0:S1 1:S3 2:S2 3:S4), channel s%6
    task automatic do_slot(input int s, input bit bad);
        int  g, ch, op, add, total;
        bit  car;
        exp_t e;
        g  = s / 6;
        ch = s % 6;
        op = ops[g];
        @(negedge clk);
        zero      = (s == 0) && !bad;
        s1_enters = !bad && (g == 0);
        s3_enters = !bad && (g == 1);
        s2_enters = !bad && (g == 2);
        s4_enters = !bad && (g == 3);
        alg       = 3'(cur_alg);
        op_result = 14'(op);
        clk_en    = 1'b1;
        if (!bad) begin
            if (s == 0) m_sync = 1'b1;
            case (g)
                0:       car = (cur_alg == 7);
                1:       car = (cur_alg >= 5);
                2:       car = (cur_alg >= 4);
                default: car = 1'b1;
            endcase
            add = car ? op : 0;
            if (g == 0) begin
                m_acc[ch] = add;
            end else if (g < 3) begin
                m_acc[ch] = m_acc[ch] + add;
            end else begin
                total = m_acc[ch] + op;
                e.snd = (en_dac && ch == 5) ? dac_i * 32 : sat14(total);
                e.ch  = ch;
                if (m_sync) exp_q.push_back(e);
                m_acc[ch] = 0;
            end
        end
        @(posedge clk);
        #1;
        sample_outputs();
        if (cur_gap > 0) begin
            clk_en = 1'b0;
            repeat (cur_gap) @(posedge clk);
        end
    endtask

    task automatic run_slots(input int from, input int to, input int bad_s);
        for (int s = from; s <= to; s++) begin
            do_slot(s, s == bad_s);
        end
    endtask

    task automatic frame(input string tag, input int bad_s);
        n_strobe = 0;
        run_slots(0, 23, bad_s);
        check({tag, "_strobes"}, n_strobe, (bad_s >= 0) ? 5 : 6);
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic set_ops(input int a, input int b, input int c, input int d);
        ops[0] = a;
        ops[1] = b;
        ops[2] = c;
        ops[3] = d;
    endtask

    initial begin
        rst = 1'b1;
        clk_en = 1'b0;
        zero = 1'b0;
        {s1_enters, s2_enters, s3_enters, s4_enters} = 4'b0000;
        alg = 3'd0;
        op_result = '0;
        en_dac = 1'b0;
        dac_val = '0;
        dac_i = 0;
        cur_gap = 0;
        m_sync = 1'b0;
        foreach (m_acc[i]) m_acc[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_snd", int'(snd), 0);
        check("rst_snd_ch", int'(snd_ch), 0);
        check("rst_valid", int'(snd_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // All carriers, 4 x 1000
        cur_alg = 7;
        set_ops(1000, 1000, 1000, 1000);
        frame("alg7_a", -1);
        frame("alg7_b", -1);

        // Only S4 is a carrier
        cur_alg = 0;
        set_ops(5000, 5000, 5000, -300);
        frame("alg0", -1);

        // Saturation in both directions
        cur_alg = 7;
        set_ops(8000, 8000, 8000, 8000);
        frame("sat_pos", -1);
        set_ops(-8192, -8192, -8192, -8192);
        frame("sat_neg", -1);

        // DAC overrides channel 5; the following frame is a clean sum again
        set_ops(100, 100, 100, 100);
        en_dac  = 1'b1;
        dac_val = -9'sd1;
        dac_i   = -1;
        frame("dac", -1);
        en_dac = 1'b0;
        dac_i  = 0;
        frame("post_dac", -1);

        // S4 of ch2 delivered with no group flag: no strobe for it
        set_ops(1000, 1000, 1000, 1000);
        frame("noop", 20);
        frame("post_noop", -1);

        // Reset in the middle of the S2 group
        n_strobe = 0;
        run_slots(0, 14, -1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_snd", int'(snd), 0);
        check("midrst_snd_ch", int'(snd_ch), 0);
        check("midrst_valid", int'(snd_valid), 0);
        m_sync = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_slots(15, 23, -1);
        check("unsynced_strobes", n_strobe, 0);
        set_ops(-700, 300, 1200, 50);
        frame("post_rst", -1);

        // Slot advance on one clock out of six
        set_ops(1000, 1000, 1000, 1000);
        cur_gap = 5;
        frame("slow_en", -1);
        cur_gap = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
